// File: rtl/cdb_broadcaster.sv
// -----------------------------------------------------------------------------
// cdb_broadcaster
//
// Purpose:
//    Producer side of the 4-lane common data bus. Collects completed results
//    (ROB tag + value) from NUM_SRC functional-unit pipelines. Each source has
//    its own small FIFO. Up to four FIFOs are granted per cycle in round-robin
//    order, and their heads are registered onto the flattened CDB lanes.
//
// Optional feature (macro CDB_BYPASS_EN):
//    When defined, a source whose FIFO is empty but whose src_valid is high
//    competes in the grant scan. If it is granted, its input goes straight onto
//    the lane at that edge and is never written to the FIFO. When undefined,
//    every result passes through its FIFO.
//
// Ports:
//    clk                 clock, all state on posedge
//    rst_n               asynchronous active-low reset
//    flush               synchronous squash of buffered and outgoing results
//    src_valid           per-source result offered
//    src_ready           per-source accept (= FIFO not full)
//    src_tag_flat        source s tag at [TAG_W*s +: TAG_W]
//    src_data_flat       source s data at [DATA_W*s +: DATA_W]
//    cdb_valid_flat      lane L valid at bit [3-L]
//    cdb_rob_index_flat  lane L tag at [TAG_W*(3-L) +: TAG_W]
//    cdb_result_flat     lane L data at [DATA_W*(3-L) +: DATA_W]
// -----------------------------------------------------------------------------
module cdb_broadcaster #(
   parameter int NUM_SRC    = 6,
   parameter int FIFO_DEPTH = 2,
   parameter int TAG_W      = 4,
   parameter int DATA_W     = 16
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      flush,
   input  logic [NUM_SRC-1:0]        src_valid,
   output logic [NUM_SRC-1:0]        src_ready,
   input  logic [NUM_SRC*TAG_W-1:0]  src_tag_flat,
   input  logic [NUM_SRC*DATA_W-1:0] src_data_flat,
   output logic [3:0]                cdb_valid_flat,
   output logic [4*TAG_W-1:0]        cdb_rob_index_flat,
   output logic [4*DATA_W-1:0]       cdb_result_flat
);

   localparam int NUM_LANES = 4;
   localparam int ENTRY_W   = TAG_W + DATA_W;
   localparam int PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W     = $clog2(FIFO_DEPTH + 1);
   localparam int SRC_W     = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
   localparam int LANE_W    = 2;

   // Per-source status and handshake
   logic [NUM_SRC-1:0] fifo_empty;
   logic [NUM_SRC-1:0] fifo_full;
   logic [NUM_SRC-1:0] cand;        // source competes in this cycle's scan
   logic [NUM_SRC-1:0] push;
   logic [NUM_SRC-1:0] pop;
   logic [NUM_SRC-1:0] grant;
   logic [LANE_W-1:0]  grant_lane [NUM_SRC];
   logic [ENTRY_W-1:0] head_entry [NUM_SRC];  // what the source puts on a lane if granted

   // Round-robin state and scan temporaries
   logic [SRC_W-1:0]   rr_ptr_reg;
   logic [SRC_W-1:0]   rr_ptr_next;
   logic [SRC_W:0]     scan_sum;
   logic [SRC_W-1:0]   scan_idx;
   logic [2:0]         n_granted;

   // Lane registers
   logic [NUM_LANES-1:0] lane_valid_reg;
   logic [NUM_LANES-1:0] lane_valid_next;
   logic [ENTRY_W-1:0]   lane_entry_reg  [NUM_LANES];
   logic [ENTRY_W-1:0]   lane_entry_next [NUM_LANES];

   // -------------------------------------------------------------------------
   // Per-source FIFOs
   // -------------------------------------------------------------------------
   generate
      for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
         logic [ENTRY_W-1:0] mem_reg [FIFO_DEPTH];
         logic [PTR_W-1:0]   wr_ptr_reg;
         logic [PTR_W-1:0]   rd_ptr_reg;
         logic [CNT_W-1:0]   count_reg;
         logic [ENTRY_W-1:0] in_entry;

         assign in_entry = {src_tag_flat[TAG_W*gi +: TAG_W],
                            src_data_flat[DATA_W*gi +: DATA_W]};

         assign fifo_empty[gi] = (count_reg == '0);
         assign fifo_full[gi]  = (count_reg == CNT_W'(FIFO_DEPTH));

         // Ready looks only at occupancy: a full FIFO refuses even when it is
         // being popped this cycle, which costs one bubble but keeps ready
         // free of any path from the grant logic.
         assign src_ready[gi] = ~fifo_full[gi];

`ifdef CDB_BYPASS_EN
         assign cand[gi]       = ~fifo_empty[gi] | src_valid[gi];
         assign head_entry[gi] = fifo_empty[gi] ? in_entry : mem_reg[rd_ptr_reg];
         // A bypassed result is consumed by the lane, so it is not written.
         assign push[gi] = src_valid[gi] & src_ready[gi] & ~flush
                           & ~(grant[gi] & fifo_empty[gi]);
`else
         assign cand[gi]       = ~fifo_empty[gi];
         assign head_entry[gi] = mem_reg[rd_ptr_reg];
         assign push[gi]       = src_valid[gi] & src_ready[gi] & ~flush;
`endif
         assign pop[gi] = grant[gi] & ~fifo_empty[gi];

         // Storage carries no reset; occupancy tracking decides what is live.
         always_ff @(posedge clk) begin
            if (push[gi]) begin
               mem_reg[wr_ptr_reg] <= in_entry;
            end
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               wr_ptr_reg <= '0;
               rd_ptr_reg <= '0;
               count_reg  <= '0;
            end else if (flush) begin
               wr_ptr_reg <= '0;
               rd_ptr_reg <= '0;
               count_reg  <= '0;
            end else begin
               if (push[gi]) begin
                  wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
               end
               if (pop[gi]) begin
                  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
               end
               case ({push[gi], pop[gi]})
                  2'b10:   count_reg <= count_reg + CNT_W'(1);
                  2'b01:   count_reg <= count_reg - CNT_W'(1);
                  default: count_reg <= count_reg;
               endcase
            end
         end
      end
   endgenerate

   // -------------------------------------------------------------------------
   // Round-robin grant: walk sources from rr_ptr and take the first four
   // candidates; the k-th one found owns lane k.
   // -------------------------------------------------------------------------
   always_comb begin
      grant       = '0;
      rr_ptr_next = rr_ptr_reg;
      n_granted   = '0;
      scan_sum    = '0;
      scan_idx    = '0;
      for (int s = 0; s < NUM_SRC; s++) begin
         grant_lane[s] = '0;
      end
      for (int i = 0; i < NUM_SRC; i++) begin
         scan_sum = {1'b0, rr_ptr_reg} + (SRC_W+1)'(i);
         if (scan_sum >= (SRC_W+1)'(NUM_SRC)) begin
            scan_sum = scan_sum - (SRC_W+1)'(NUM_SRC);
         end
         scan_idx = scan_sum[SRC_W-1:0];
         if (cand[scan_idx] && (n_granted < 3'd4)) begin
            grant[scan_idx]      = 1'b1;
            grant_lane[scan_idx] = n_granted[LANE_W-1:0];
            n_granted            = n_granted + 3'd1;
            // Next scan starts just after the last source served.
            rr_ptr_next = (scan_idx == SRC_W'(NUM_SRC - 1)) ? '0
                                                            : scan_idx + SRC_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr_reg <= '0;
      end else if (!flush) begin
         rr_ptr_reg <= rr_ptr_next;
      end
   end

   // -------------------------------------------------------------------------
   // Lane steering and output registers
   // -------------------------------------------------------------------------
   always_comb begin
      for (int l = 0; l < NUM_LANES; l++) begin
         lane_valid_next[l] = 1'b0;
         lane_entry_next[l] = '0;
      end
      for (int s = 0; s < NUM_SRC; s++) begin
         if (grant[s]) begin
            lane_valid_next[grant_lane[s]] = 1'b1;
            lane_entry_next[grant_lane[s]] = head_entry[s];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lane_valid_reg <= '0;
         for (int l = 0; l < NUM_LANES; l++) begin
            lane_entry_reg[l] <= '0;
         end
      end else if (flush) begin
         lane_valid_reg <= '0;
         for (int l = 0; l < NUM_LANES; l++) begin
            lane_entry_reg[l] <= '0;
         end
      end else begin
         lane_valid_reg <= lane_valid_next;
         for (int l = 0; l < NUM_LANES; l++) begin
            lane_entry_reg[l] <= lane_entry_next[l];
         end
      end
   end

   // Lane 0 sits in the most significant slot of each flattened bus.
   generate
      for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
         assign cdb_valid_flat[3-gi]                        = lane_valid_reg[gi];
         assign cdb_rob_index_flat[TAG_W*(3-gi) +: TAG_W]   = lane_entry_reg[gi][DATA_W +: TAG_W];
         assign cdb_result_flat[DATA_W*(3-gi) +: DATA_W]    = lane_entry_reg[gi][DATA_W-1:0];
      end
   endgenerate

endmodule

// File: tb/tb_cdb_broadcaster.sv
module tb_cdb_broadcaster;

   localparam int NUM_SRC    = 6;
   localparam int FIFO_DEPTH = 2;
   localparam int TAG_W      = 4;
   localparam int DATA_W     = 16;
   localparam int ENTRY_W    = TAG_W + DATA_W;
`ifdef CDB_BYPASS_EN
   localparam int LAT = 1;
`else
   localparam int LAT = 2;
`endif

   typedef logic [ENTRY_W-1:0] item_t;

   logic                      clk;
   logic                      rst_n;
   logic                      flush;
   logic [NUM_SRC-1:0]        src_valid;
   logic [NUM_SRC-1:0]        src_ready;
   logic [NUM_SRC*TAG_W-1:0]  src_tag_flat;
   logic [NUM_SRC*DATA_W-1:0] src_data_flat;
   logic [3:0]                cdb_valid_flat;
   logic [4*TAG_W-1:0]        cdb_rob_index_flat;
   logic [4*DATA_W-1:0]       cdb_result_flat;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   cdb_broadcaster #(
      .NUM_SRC   (NUM_SRC),
      .FIFO_DEPTH(FIFO_DEPTH),
      .TAG_W     (TAG_W),
      .DATA_W    (DATA_W)
   ) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .flush             (flush),
      .src_valid         (src_valid),
      .src_ready         (src_ready),
      .src_tag_flat      (src_tag_flat),
      .src_data_flat     (src_data_flat),
      .cdb_valid_flat    (cdb_valid_flat),
      .cdb_rob_index_flat(cdb_rob_index_flat),
      .cdb_result_flat   (cdb_result_flat)
   );

   int    n_checks = 0;
   int    n_fails  = 0;
   item_t pend_q [NUM_SRC][$];   // results waiting to be offered
   item_t exp_q  [NUM_SRC][$];   // accepted results, oldest first
   int    grant_cnt [NUM_SRC];
   bit    mon_en  = 1'b0;
   bit    bp_seen = 1'b0;
   int    seq     = 0;

   // Data carries the source number in its top nibble and a sequence number
   // below it, so every result on the bus is unique.
   function automatic item_t mk_item(input int s, input int tag, input int n);
      item_t it;
      it = {TAG_W'(tag), 4'(s), 12'(n)};
      return it;
   endfunction

   function automatic bit busy();
      for (int s = 0; s < NUM_SRC; s++) begin
         if (pend_q[s].size() != 0 || exp_q[s].size() != 0) return 1'b1;
      end
      return 1'b0;
   endfunction

   // ------------------------------------------------------------------------
   // Bus monitor: every valid lane must be the oldest outstanding result of
   // some source; valid lanes are packed from lane 0; idle lanes read zero.
   // ------------------------------------------------------------------------
   logic  mon_v;
   item_t mon_got;
   int    mon_hit;

   always @(negedge clk) begin
      if (mon_en && rst_n) begin
         for (int l = 0; l < 4; l++) begin
            mon_v   = cdb_valid_flat[3-l];
            mon_got = {cdb_rob_index_flat[TAG_W*(3-l) +: TAG_W],
                       cdb_result_flat[DATA_W*(3-l) +: DATA_W]};
            mon_hit = -1;
            n_checks++;
            if (mon_v) begin
               for (int s = 0; s < NUM_SRC; s++) begin
                  if (mon_hit < 0 && exp_q[s].size() > 0 && exp_q[s][0] == mon_got) mon_hit = s;
               end
               if (mon_hit < 0) begin
                  n_fails++;
                  $display("FAIL bus_item lane %0d: got tag=%h data=%h, required the oldest outstanding result of some source",
                           l, mon_got[ENTRY_W-1 -: TAG_W], mon_got[DATA_W-1:0]);
               end else begin
                  void'(exp_q[mon_hit].pop_front());
                  grant_cnt[mon_hit]++;
               end
               if (l > 0) begin
                  n_checks++;
                  if (cdb_valid_flat[4-l] !== 1'b1) begin
                     n_fails++;
                     $display("FAIL lane_packing: got valid=%b, required no gap before lane %0d",
                              cdb_valid_flat, l);
                  end
               end
            end else if (mon_got !== '0) begin
               n_fails++;
               $display("FAIL idle_lane_zero lane %0d: got %h, required 0", l, mon_got);
            end
         end
      end
   end

   // One cycle of stimulus: offer each source's pending head; an item seen
   // with ready high is accepted at the coming edge.
   task automatic step(input bit do_flush);
      item_t it;
      @(posedge clk);
      #1;
      flush         = do_flush;
      src_valid     = '0;
      src_tag_flat  = '0;
      src_data_flat = '0;
      for (int s = 0; s < NUM_SRC; s++) begin
         if (pend_q[s].size() > 0) begin
            it = pend_q[s][0];
            src_valid[s] = 1'b1;
            src_tag_flat[TAG_W*s +: TAG_W]    = it[ENTRY_W-1 -: TAG_W];
            src_data_flat[DATA_W*s +: DATA_W] = it[DATA_W-1:0];
            if (src_ready[s]) begin
               void'(pend_q[s].pop_front());
               if (!do_flush) exp_q[s].push_back(it);
            end else if (s == 0) begin
               bp_seen = 1'b1;
            end
         end
      end
      if (do_flush) begin
         for (int s = 0; s < NUM_SRC; s++) pend_q[s].delete();
         // Let the monitor see what is on the bus before the flush edge.
         @(negedge clk);
         #1;
         for (int s = 0; s < NUM_SRC; s++) exp_q[s].delete();
      end
   endtask

   task automatic drain(output bit ok);
      int guard;
      guard = 0;
      while (busy() && guard < 60) begin
         step(1'b0);
         guard++;
      end
      ok = !busy();
   endtask

   // ------------------------------------------------------------------------
   task automatic test_reset();
      rst_n         = 1'b1;
      flush         = 1'b0;
      src_valid     = '0;
      src_tag_flat  = '0;
      src_data_flat = '0;
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if (cdb_valid_flat !== 4'b0000) begin
         n_fails++;
         $display("FAIL reset_valid: got %b, required 0000", cdb_valid_flat);
      end
      n_checks++;
      if (cdb_rob_index_flat !== '0 || cdb_result_flat !== '0) begin
         n_fails++;
         $display("FAIL reset_bus: got tag=%h data=%h, required 0", cdb_rob_index_flat, cdb_result_flat);
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      n_checks++;
      if (src_ready !== {NUM_SRC{1'b1}}) begin
         n_fails++;
         $display("FAIL reset_ready: got %b, required all ones", src_ready);
      end
      mon_en = 1'b1;
   endtask

   task automatic test_overload(input int round);
      bit         ok;
      logic [3:0] exp_v;
      drain(ok);
      for (int s = 0; s < NUM_SRC; s++) begin
         pend_q[s].push_back(mk_item(s, s, seq));
         seq++;
      end
      step(1'b0);
      for (int k = 1; k <= 4; k++) begin
         step(1'b0);
         exp_v = (k == LAT) ? 4'b1111 : (k == LAT + 1) ? 4'b1100 : 4'b0000;
         n_checks++;
         if (cdb_valid_flat !== exp_v) begin
            n_fails++;
            $display("FAIL overload_valid r%0d k%0d: got %b, required %b", round, k, cdb_valid_flat, exp_v);
         end
         if (k == LAT) begin
            n_checks++;
            if (cdb_rob_index_flat !== 16'h0123) begin
               n_fails++;
               $display("FAIL overload_tags_a r%0d: got %h, required 0123", round, cdb_rob_index_flat);
            end
         end
         if (k == LAT + 1) begin
            n_checks++;
            if (cdb_rob_index_flat !== 16'h4500) begin
               n_fails++;
               $display("FAIL overload_tags_b r%0d: got %h, required 4500", round, cdb_rob_index_flat);
            end
         end
      end
   endtask

   task automatic test_single();
      bit         ok;
      logic [3:0] exp_v;
      drain(ok);
      pend_q[2].push_back({4'h5, 16'hBEEF});
      step(1'b0);
      for (int k = 1; k <= 3; k++) begin
         step(1'b0);
         exp_v = (k == LAT) ? 4'b1000 : 4'b0000;
         n_checks++;
         if (cdb_valid_flat !== exp_v) begin
            n_fails++;
            $display("FAIL single_valid k%0d: got %b, required %b", k, cdb_valid_flat, exp_v);
         end
         if (k == LAT) begin
            n_checks++;
            if (cdb_rob_index_flat[15:12] !== 4'h5 || cdb_result_flat[63:48] !== 16'hBEEF) begin
               n_fails++;
               $display("FAIL single_payload: got tag=%h data=%h, required tag=5 data=beef",
                        cdb_rob_index_flat[15:12], cdb_result_flat[63:48]);
            end
         end
      end
   endtask

   task automatic test_backpressure();
      bit ok;
      int guard;
      drain(ok);
      bp_seen = 1'b0;
      foreach (grant_cnt[s]) grant_cnt[s] = 0;
      for (int n = 1; n <= 8; n++) begin
         pend_q[0].push_back(mk_item(0, n, seq));
         seq++;
      end
      for (int s = 1; s < NUM_SRC; s++) begin
         for (int n = 0; n < 8; n++) begin
            pend_q[s].push_back(mk_item(s, $urandom_range(0, 15), seq));
            seq++;
         end
      end
      guard = 0;
      while (pend_q[0].size() > 0 && guard < 40) begin
         step(1'b0);
         guard++;
      end
      n_checks++;
      if (!bp_seen) begin
         n_fails++;
         $display("FAIL backpressure_ready: got src_ready[0] never low, required low while full");
      end
      drain(ok);
      n_checks++;
      if (!ok) begin
         n_fails++;
         $display("FAIL backpressure_drain: got results outstanding, required all delivered");
      end
      n_checks++;
      if (grant_cnt[0] != 8) begin
         n_fails++;
         $display("FAIL backpressure_count: got %0d src0 results, required 8", grant_cnt[0]);
      end
   endtask

   task automatic test_fairness();
      bit ok;
      drain(ok);
      for (int s = 0; s < NUM_SRC; s++) begin
         for (int n = 0; n < 14; n++) begin
            pend_q[s].push_back(mk_item(s, n, seq));
            seq++;
         end
      end
      repeat (4) step(1'b0);
      foreach (grant_cnt[s]) grant_cnt[s] = 0;
      repeat (3) step(1'b0);
      for (int s = 0; s < NUM_SRC; s++) begin
         n_checks++;
         if (grant_cnt[s] != 2) begin
            n_fails++;
            $display("FAIL fairness src%0d: got %0d grants in 3 cycles, required 2", s, grant_cnt[s]);
         end
      end
      drain(ok);
      n_checks++;
      if (!ok) begin
         n_fails++;
         $display("FAIL fairness_drain: got results outstanding, required all delivered");
      end
   endtask

   task automatic test_flush();
      bit ok;
      drain(ok);
      for (int s = 0; s < NUM_SRC; s++) begin
         for (int n = 0; n < 4; n++) begin
            pend_q[s].push_back(mk_item(s, n, seq));
            seq++;
         end
      end
      repeat (3) step(1'b0);
      step(1'b1);
      step(1'b0);
      n_checks++;
      if (cdb_valid_flat !== 4'b0000) begin
         n_fails++;
         $display("FAIL flush_bus: got %b, required 0000", cdb_valid_flat);
      end
      n_checks++;
      if (src_ready !== {NUM_SRC{1'b1}}) begin
         n_fails++;
         $display("FAIL flush_ready: got %b, required all ones", src_ready);
      end
      // Any stale result surfacing here is caught by the monitor.
      repeat (5) step(1'b0);
      pend_q[1].push_back(mk_item(1, 9, seq));
      seq++;
      drain(ok);
      n_checks++;
      if (!ok) begin
         n_fails++;
         $display("FAIL flush_recover: got result outstanding, required delivered");
      end
   endtask

   task automatic test_mid_reset();
      for (int s = 0; s < NUM_SRC; s++) begin
         for (int n = 0; n < 6; n++) begin
            pend_q[s].push_back(mk_item(s, n, seq));
            seq++;
         end
      end
      repeat (3) step(1'b0);
      @(posedge clk);
      #2;
      n_checks++;
      if (cdb_valid_flat === 4'b0000) begin
         n_fails++;
         $display("FAIL midreset_busy: got bus idle, required traffic before reset");
      end
      mon_en    = 1'b0;
      rst_n     = 1'b0;
      src_valid = '0;
      for (int s = 0; s < NUM_SRC; s++) begin
         pend_q[s].delete();
         exp_q[s].delete();
      end
      #1;
      n_checks++;
      if (cdb_valid_flat !== 4'b0000 || cdb_rob_index_flat !== '0 || cdb_result_flat !== '0) begin
         n_fails++;
         $display("FAIL midreset_outputs: got v=%b tag=%h data=%h, required all 0",
                  cdb_valid_flat, cdb_rob_index_flat, cdb_result_flat);
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      n_checks++;
      if (src_ready !== {NUM_SRC{1'b1}}) begin
         n_fails++;
         $display("FAIL midreset_ready: got %b, required all ones", src_ready);
      end
      mon_en = 1'b1;
      test_overload(3);
   endtask

   task automatic test_back_to_back();
      bit ok;
      drain(ok);
      for (int c = 0; c < 50; c++) begin
         for (int s = 0; s < NUM_SRC; s++) begin
            if ($urandom_range(0, 1) == 1 && pend_q[s].size() < 3) begin
               pend_q[s].push_back(mk_item(s, $urandom_range(0, 15), seq));
               seq++;
            end
         end
         step(1'b0);
      end
      drain(ok);
      n_checks++;
      if (!ok) begin
         n_fails++;
         $display("FAIL b2b_drain: got results outstanding, required all delivered");
      end
   endtask

   initial begin
      test_reset();
      test_overload(1);
      test_overload(2);
      test_single();
      test_backpressure();
      test_fairness();
      test_flush();
      test_mid_reset();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no completion, required finish within time limit");
      $fatal(1, "watchdog");
   end

endmodule
